// File: rtl/ats21_client_arbiter.sv
// Round-robin sharer of one ATS21 client port: serialises each 32-bit host instruction as two 16-bit beats,
// retries on Nack and returns the final status; one instruction in flight, hosts wait on req_ready.
module ats21_client_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int RESP_LAT  = 1,
    parameter int MAX_RETRY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*32-1:0]  req_instr,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic                   rsp_ack,
    output logic                   ats_req,
    output logic [15:0]            ats_ctrl,
    input  logic                   ats_stat,
    output logic                   busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, HI, LO, WAIT, DONE, GAP} state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     win_q, win_d;
    logic [31:0]          instr_q, instr_d;
    logic                 nop_q, nop_d;
    logic [2:0]           wait_cnt_q, wait_cnt_d;
    logic [2:0]           retry_q, retry_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic                 rsp_ack_q, rsp_ack_d;
    logic                 ats_req_q, ats_req_d;
    logic [15:0]          ats_ctrl_q, ats_ctrl_d;
    logic                 busy_q, busy_d;

    logic                 grant_vld;
    logic [PTR_W-1:0]     grant_idx;
    logic [31:0]          grant_instr;

    // First valid host at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin : arb
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] cand;
        sum       = '0;
        cand      = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            cand = sum[PTR_W-1:0];
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_instr = req_instr[32*grant_idx +: 32];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        instr_d     = instr_q;
        nop_d       = nop_q;
        wait_cnt_d  = wait_cnt_q;
        retry_d     = retry_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_ack_d   = 1'b0;
        ats_req_d   = 1'b0;
        ats_ctrl_d  = ats_ctrl_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    win_d       = grant_idx;
                    instr_d     = grant_instr;
                    req_ready_d = NUM_REQ'(1) << grant_idx;
                    if (grant_instr[31:29] == 3'b000) begin
                        nop_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        nop_d      = 1'b0;
                        state_d    = HI;
                        ats_req_d  = 1'b1;
                        ats_ctrl_d = grant_instr[31:16];
                    end
                end
            end
            HI: begin
                state_d    = LO;
                ats_ctrl_d = instr_q[15:0];
            end
            LO: begin
                state_d    = WAIT;
                wait_cnt_d = 3'(RESP_LAT);
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - 3'd1;
                if (wait_cnt_q <= 3'd1) begin
                    if (ats_stat || retry_q >= 3'(MAX_RETRY)) begin
                        state_d     = DONE;
                        rsp_valid_d = NUM_REQ'(1) << win_q;
                        rsp_ack_d   = ats_stat;
                    end else begin
                        retry_d = retry_q + 3'd1;
                        state_d = GAP;
                    end
                end
            end
            DONE: begin
                // A nop reaches DONE straight from IDLE, so its response goes out on the way to GAP.
                if (nop_q) begin
                    rsp_valid_d = NUM_REQ'(1) << win_q;
                    rsp_ack_d   = 1'b1;
                end
                rr_ptr_d = (win_q == PTR_W'(NUM_REQ-1)) ? '0 : win_q + PTR_W'(1);
                retry_d  = '0;
                state_d  = GAP;
            end
            GAP: begin
                // Non-zero retry count here means we came from a Nack, not from DONE.
                if (retry_q != 3'd0) begin
                    state_d    = HI;
                    ats_req_d  = 1'b1;
                    ats_ctrl_d = instr_q[31:16];
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            instr_q     <= '0;
            nop_q       <= 1'b0;
            wait_cnt_q  <= '0;
            retry_q     <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_ack_q   <= 1'b0;
            ats_req_q   <= 1'b0;
            ats_ctrl_q  <= 16'h0000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            instr_q     <= instr_d;
            nop_q       <= nop_d;
            wait_cnt_q  <= wait_cnt_d;
            retry_q     <= retry_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ack_q   <= rsp_ack_d;
            ats_req_q   <= ats_req_d;
            ats_ctrl_q  <= ats_ctrl_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_ack   = rsp_ack_q;
    assign ats_req   = ats_req_q;
    assign ats_ctrl  = ats_ctrl_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ats21_client_arbiter.sv
// Randomised host/ATS21 traffic against a transaction-level model of grant order, beat timing and status.
module tb_ats21_client_arbiter;

    localparam int N   = 4;
    localparam int L   = 1;
    localparam int MR  = 2;
    localparam int PER = L + 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*32-1:0]   req_instr;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic              rsp_ack;
    logic              ats_req;
    logic [15:0]       ats_ctrl;
    logic              ats_stat;
    logic              busy;

    ats21_client_arbiter #(.NUM_REQ(N), .RESP_LAT(L), .MAX_RETRY(MR)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_instr(req_instr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
        .ats_req(ats_req), .ats_ctrl(ats_ctrl), .ats_stat(ats_stat), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Transaction model
    int          rr, w, t_g, t_rsp, n_iss, nplan, last_rsp, last_hi, idle_wait;
    bit          inflt, isnop;
    logic        exp_ack;
    logic [31:0] ins;
    int          gq[$];

    // Host model and knobs
    logic [N-1:0] pend, en;
    logic [31:0]  hins[N];
    int           p_new, p_drop, nop_pct, force_plan;

    // Directed observations
    int   obs_grant, obs_rsp, hi_cnt;
    logic obs_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] new_instr();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 99) < nop_pct) v[31:29] = 3'b000;
        else if (v[31:29] == 3'b000) v[31:29] = 3'b101;
        return v;
    endfunction

    task automatic model_reset();
        inflt = 0; rr = 0; last_rsp = -1; last_hi = -1; idle_wait = 0;
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = pend[i];
            req_instr[32*i +: 32]  = hins[i];
        end
    endtask

    task automatic start_txn(input int h);
        w       = h;
        ins     = req_instr[32*h +: 32];
        isnop   = (ins[31:29] == 3'b000);
        nplan   = (force_plan >= 0) ? force_plan : int'($urandom_range(0, 3));
        n_iss   = isnop ? 0 : ((nplan < MR) ? nplan : MR) + 1;
        exp_ack = isnop || (nplan <= MR);
        t_g     = cyc;
        t_rsp   = isnop ? cyc + 1 : cyc + L + 2 + (n_iss - 1) * PER;
        if (last_rsp >= 0) check("b2b_gap", (cyc - last_rsp) >= 2, 1);
        if (!isnop && last_hi >= 0) check("req_sep", (cyc - last_hi) >= 5, 1);
        inflt = 1; idle_wait = 0; pend[h] = 1'b0;
        gq.push_back(h);
    endtask

    task automatic observe();
        int ew, rel;
        bit hi, lo;
        if (ats_req) hi_cnt++;
        if (rsp_valid != '0) begin obs_rsp = cyc; obs_ack = rsp_ack; end
        if (req_ready != '0) begin
            obs_grant = cyc;
            if (inflt) check("ready_in_flight", req_ready, 0);
            else begin
                ew = -1;
                for (int i = 0; i < N; i++)
                    if (ew < 0 && req_valid[(rr + i) % N]) ew = (rr + i) % N;
                check("grant", req_ready, (ew < 0) ? 0 : (1 << ew));
                if (ew >= 0) start_txn(ew);
            end
        end else if (!inflt && req_valid != '0) begin
            idle_wait++;
            if (idle_wait == 8) check("grant_timeout", idle_wait, 0);
        end
        if (inflt) begin
            rel = cyc - t_g;
            hi  = !isnop && (rel % PER == 0) && (rel / PER < n_iss);
            lo  = !isnop && (rel % PER == 1) && (rel / PER < n_iss);
            check("ats_req", ats_req, hi);
            if (hi) check("ctrl_hi", ats_ctrl, ins[31:16]);
            if (lo) check("ctrl_lo", ats_ctrl, ins[15:0]);
            check("busy", busy, 1);
            if (cyc == t_rsp) begin
                check("rsp_valid", rsp_valid, 1 << w);
                check("rsp_ack", rsp_ack, exp_ack);
                inflt = 0; last_rsp = cyc; rr = (w + 1) % N;
            end else begin
                check("rsp_valid", rsp_valid, 0);
            end
        end else begin
            check("ats_req_idle", ats_req, 0);
            check("rsp_idle", rsp_valid, 0);
        end
        if (ats_req) last_hi = cyc;
    endtask

    task automatic drive();
        int rel, s;
        ats_stat = 1'($urandom_range(0, 1));
        if (inflt && !isnop) begin
            rel = cyc - t_g;
            s   = rel - (1 + L);
            if (s >= 0 && s % PER == 0 && s / PER < n_iss) ats_stat = (s / PER >= nplan);
        end
        for (int i = 0; i < N; i++) begin
            if (en[i] && !pend[i] && $urandom_range(0, 99) < p_new) begin
                pend[i] = 1'b1;
                hins[i] = new_instr();
            end else if (en[i] && pend[i] && $urandom_range(0, 99) < p_drop) begin
                pend[i] = 1'b0;
            end
            if (!pend[i]) hins[i] = $urandom;
        end
        apply();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        observe();
        drive();
    endtask

    task automatic drain();
        en = '0;
        for (int k = 0; k < 200 && (inflt || pend != '0); k++) step();
        check("drain", {31'd0, inflt}, 0);
        repeat (4) step();
    endtask

    task automatic single(input string tag, input int h, input logic [31:0] iv, input int plan,
                          input int e_lat, input int e_beats, input logic e_ack);
        drain();
        force_plan = plan;
        pend = '0; pend[h] = 1'b1; hins[h] = iv;
        apply();
        obs_grant = -1; obs_rsp = -1; hi_cnt = 0;
        for (int k = 0; k < 80 && obs_rsp < 0; k++) step();
        check({tag, "_seen"}, obs_rsp >= 0, 1);
        check({tag, "_lat"}, obs_rsp - obs_grant, e_lat);
        check({tag, "_beats"}, hi_cnt, e_beats);
        check({tag, "_ack"}, obs_ack, e_ack);
    endtask

    task automatic reset_mid_wait_then_all();
        drain();
        force_plan = 0;
        pend = '0; pend[1] = 1'b1; hins[1] = 32'h4321_8765;
        apply();
        for (int k = 0; k < 40 && !(inflt && cyc == t_g + 2); k++) step();
        check("t1_in_wait", {31'd0, inflt}, 1);
        reset = 1'b0;
        #1;
        check("t1_async", {req_ready, rsp_valid, rsp_ack, ats_req, busy}, 0);
        check("t1_ctrl", ats_ctrl, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            check("t1_hold", {req_ready, rsp_valid, ats_req, busy}, 0);
        end
        model_reset();
        en = '1; p_new = 100; p_drop = 0; nop_pct = 0; force_plan = 0;
        pend = '1;
        for (int i = 0; i < N; i++) hins[i] = new_instr();
        apply();
        gq.delete();
        reset = 1'b1;
        for (int k = 0; k < 100 && gq.size() < 5; k++) step();
        check("t5_grants", gq.size(), 5);
        for (int k = 0; k < gq.size() && k < 5; k++) check("t5_order", gq[k], k % N);
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_instr = '0; ats_stat = 1'b0;
        pend = '0; en = '0; p_new = 0; p_drop = 0; nop_pct = 0; force_plan = -1;
        for (int i = 0; i < N; i++) hins[i] = '0;
        obs_grant = -1; obs_rsp = -1; hi_cnt = 0; obs_ack = 1'b0;
        model_reset();
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {req_ready, rsp_valid, rsp_ack, ats_req, busy}, 0);
        check("reset_ctrl", ats_ctrl, 0);
        reset = 1'b1;
        apply();

        single("t2", 1, 32'h2A40_0005, 0, 3, 1, 1'b1);
        single("t3", 0, 32'h0000_1234, 0, 1, 0, 1'b1);
        single("t4", 3, 32'h6000_BEEF, 3, 11, 3, 1'b0);
        single("t6", 2, 32'hC0DE_0042, 1, 7, 2, 1'b1);

        en = '1; p_new = 30; p_drop = 5; nop_pct = 25; force_plan = -1;
        repeat (1500) step();

        reset_mid_wait_then_all();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
